// File: rtl/db_mv_pingpong_buf_if.sv
// Handshake bundle between the MV producer/consumer pair and the ping-pong MV buffer.
// The master side drives the strobes; the buffer (slave) returns data and bank status.
interface db_mv_pingpong_buf_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 20
) ();
    logic                  wr_en_i;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  wr_done_i;
    logic                  wr_rdy_o;
    logic                  rd_en_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;
    logic                  rd_done_i;
    logic                  rd_rdy_o;
    logic                  wr_bank_o;
    logic                  rd_bank_o;
    logic                  err_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, wr_done_i,
        output rd_en_i, rd_addr_i, rd_done_i,
        input  wr_rdy_o, rd_data_o, rd_valid_o, rd_rdy_o,
        input  wr_bank_o, rd_bank_o, err_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, wr_done_i,
        input  rd_en_i, rd_addr_i, rd_done_i,
        output wr_rdy_o, rd_data_o, rd_valid_o, rd_rdy_o,
        output wr_bank_o, rd_bank_o, err_o
    );
endinterface

// File: rtl/db_mv_pingpong_buf.sv
// Two-bank ping-pong MV buffer between prediction (writer) and deblocking (reader).
// A per-entry valid bitmap lets never-written positions read back as zero MV.
module db_mv_pingpong_buf #(
    parameter int MV_WIDTH       = 10,
    parameter int DATA_WIDTH     = 2 * MV_WIDTH,
    parameter int ADDR_WIDTH     = 7,
    parameter int ZERO_UNWRITTEN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    db_mv_pingpong_buf_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } bank_state_t;

    bank_state_t r_state [2];
    bank_state_t w_state_next [2];
    logic        r_wr_bank, w_wr_bank_next;
    logic        r_rd_bank, w_rd_bank_next;
    logic        r_err;
    logic        r_rd_valid;
    logic        r_rd_zero;
    logic [DATA_WIDTH-1:0] r_rd_ram;
    logic [DATA_WIDTH-1:0] r_mem [0:2*DEPTH-1];
    logic [1:0]  w_valid_bit;

    logic w_wr_rdy, w_rd_rdy;
    logic w_wr_acc, w_wr_done_acc, w_rd_acc, w_rd_done_acc, w_err;

    assign w_wr_rdy      = (r_state[r_wr_bank] != ST_FULL);
    assign w_rd_rdy      = (r_state[r_rd_bank] == ST_FULL);
    assign w_wr_acc      = bus.wr_en_i   & w_wr_rdy;
    assign w_wr_done_acc = bus.wr_done_i & w_wr_rdy;
    assign w_rd_acc      = bus.rd_en_i   & w_rd_rdy;
    assign w_rd_done_acc = bus.rd_done_i & w_rd_rdy;
    assign w_err = ((bus.wr_en_i | bus.wr_done_i) & ~w_wr_rdy) |
                   ((bus.rd_en_i | bus.rd_done_i) & ~w_rd_rdy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state[0] <= ST_EMPTY;
            r_state[1] <= ST_EMPTY;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wr_bank  <= w_wr_bank_next;
            r_rd_bank  <= w_rd_bank_next;
            r_err      <= r_err | w_err;
        end
    end

    // Release is applied first so the writer can claim a bank freed in the same cycle.
    always_comb begin
        w_state_next   = r_state;
        w_wr_bank_next = r_wr_bank;
        w_rd_bank_next = r_rd_bank;
        if (w_rd_done_acc)
            w_state_next[r_rd_bank] = ST_EMPTY;
        if (w_wr_acc && r_state[r_wr_bank] == ST_EMPTY)
            w_state_next[r_wr_bank] = ST_FILLING;
        if (w_wr_done_acc)
            w_state_next[r_wr_bank] = ST_FULL;
        if (w_state_next[r_wr_bank] == ST_FULL && w_state_next[~r_wr_bank] == ST_EMPTY)
            w_wr_bank_next = ~r_wr_bank;
        if (w_state_next[r_rd_bank] != ST_FULL && w_state_next[~r_rd_bank] == ST_FULL)
            w_rd_bank_next = ~r_rd_bank;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [DEPTH-1:0] r_valid;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_valid <= '0;
                else if (w_rd_done_acc && r_rd_bank == 1'(gi))
                    r_valid <= '0;
                else if (w_wr_acc && r_wr_bank == 1'(gi))
                    r_valid[bus.wr_addr_i] <= 1'b1;
            end
            assign w_valid_bit[gi] = r_valid[bus.rd_addr_i];
        end
    endgenerate

    // Storage has no reset so it maps onto block RAM; the read port is registered.
    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[{r_wr_bank, bus.wr_addr_i}] <= bus.wr_data_i;
        if (w_rd_acc)
            r_rd_ram <= r_mem[{r_rd_bank, bus.rd_addr_i}];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_zero  <= 1'b1;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc)
                r_rd_zero <= (ZERO_UNWRITTEN != 0) && !w_valid_bit[r_rd_bank];
        end
    end

    assign bus.rd_data_o  = r_rd_zero ? '0 : r_rd_ram;
    assign bus.rd_valid_o = r_rd_valid;
    assign bus.wr_rdy_o   = w_wr_rdy;
    assign bus.rd_rdy_o   = w_rd_rdy;
    assign bus.wr_bank_o  = r_wr_bank;
    assign bus.rd_bank_o  = r_rd_bank;
    assign bus.err_o      = r_err;
endmodule

// File: tb/tb_db_mv_pingpong_buf.sv
// Scoreboard bench for the ping-pong MV buffer: bank handover, zero-fill of unwritten
// entries, writer stall, simultaneous done pulses and asynchronous reset.
module tb_db_mv_pingpong_buf;
    localparam int AW = 7;
    localparam int DW = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [DW-1:0] sb_q [$];

    db_mv_pingpong_buf_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    db_mv_pingpong_buf #(.MV_WIDTH(10), .ADDR_WIDTH(AW), .ZERO_UNWRITTEN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rd_valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("rd_unexpected", 32'(bus.rd_valid_o), 32'd0);
            end else begin
                logic [DW-1:0] e;
                e = sb_q.pop_front();
                $display("read  data=0x%05h expected=0x%05h", bus.rd_data_o, e);
                chk("rd_data", 32'(bus.rd_data_o), 32'(e));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en_i = 1'b1; bus.wr_addr_i = a; bus.wr_data_i = d;
        cyc();
        bus.wr_en_i = 1'b0;
        $display("write addr=%0d data=0x%05h", a, d);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
        bus.rd_en_i = 1'b1; bus.rd_addr_i = a;
        sb_q.push_back(e);
        cyc();
        bus.rd_en_i = 1'b0;
        chk("rd_valid_latency", 32'(bus.rd_valid_o), 32'd1);
    endtask

    task automatic wr_done();
        bus.wr_done_i = 1'b1; cyc(); bus.wr_done_i = 1'b0;
        $display("wr_done");
    endtask

    task automatic rd_done();
        bus.rd_done_i = 1'b1; cyc(); bus.rd_done_i = 1'b0;
        $display("rd_done");
    endtask

    task automatic chk_status(input string tag, input logic wr_rdy, input logic rd_rdy,
                              input logic wr_bank, input logic rd_bank);
        chk({tag, ".wr_rdy"},  32'(bus.wr_rdy_o),  32'(wr_rdy));
        chk({tag, ".rd_rdy"},  32'(bus.rd_rdy_o),  32'(rd_rdy));
        chk({tag, ".wr_bank"}, 32'(bus.wr_bank_o), 32'(wr_bank));
        chk({tag, ".rd_bank"}, 32'(bus.rd_bank_o), 32'(rd_bank));
    endtask

    initial begin
        bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0; bus.wr_done_i = 1'b0;
        bus.rd_en_i = 1'b0; bus.rd_addr_i = '0; bus.rd_done_i = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // Reset state
        chk_status("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset.err", 32'(bus.err_o), 32'd0);
        chk("reset.rd_valid", 32'(bus.rd_valid_o), 32'd0);
        chk("reset.rd_data", 32'(bus.rd_data_o), 32'd0);

        // Single bank fill
        do_write(7'd5, 20'h0A3F1);
        wr_done();
        chk_status("fill", 1'b1, 1'b1, 1'b1, 1'b0);
        do_read(7'd5, 20'h0A3F1);
        do_read(7'd6, 20'h00000);
        cyc();
        chk("idle.rd_valid", 32'(bus.rd_valid_o), 32'd0);

        // Writer stall: bank 1 filled while bank 0 is still held by the reader
        do_write(7'd7, 20'h55555);
        wr_done();
        chk_status("stall", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("stall.err_before", 32'(bus.err_o), 32'd0);
        do_write(7'd7, 20'h99999);
        chk("stall.err_after", 32'(bus.err_o), 32'd1);
        rd_done();
        chk_status("release", 1'b1, 1'b1, 1'b0, 1'b1);
        do_read(7'd7, 20'h55555);
        do_read(7'd5, 20'h00000);

        // Bank recycle: bank 0 refilled with only addr 6
        do_write(7'd6, 20'h00003);
        wr_done();
        chk_status("refill", 1'b0, 1'b1, 1'b0, 1'b1);
        rd_done();
        chk_status("recycle", 1'b1, 1'b1, 1'b1, 1'b0);
        do_read(7'd5, 20'h00000);
        do_read(7'd6, 20'h00003);

        // Simultaneous done, with a read in the same cycle as rd_done
        do_write(7'd1, 20'hABCDE);
        bus.wr_done_i = 1'b1; bus.rd_done_i = 1'b1;
        bus.rd_en_i = 1'b1; bus.rd_addr_i = 7'd6;
        sb_q.push_back(20'h00003);
        cyc();
        bus.wr_done_i = 1'b0; bus.rd_done_i = 1'b0; bus.rd_en_i = 1'b0;
        chk("simul.rd_valid", 32'(bus.rd_valid_o), 32'd1);
        chk_status("simul", 1'b1, 1'b1, 1'b0, 1'b1);
        do_read(7'd1, 20'hABCDE);

        // Reset mid-operation with both banks FULL and a read burst in flight
        do_write(7'd2, 20'h11111);
        wr_done();
        chk_status("bothfull", 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bus.rd_en_i = 1'b1; bus.rd_addr_i = 7'd1;
            sb_q.push_back(20'hABCDE);
            cyc();
        end
        @(negedge clk);
        #1;
        #1 rst = 1'b1;
        #1;
        chk_status("async_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("async_rst.err", 32'(bus.err_o), 32'd0);
        chk("async_rst.rd_valid", 32'(bus.rd_valid_o), 32'd0);
        chk("async_rst.rd_data", 32'(bus.rd_data_o), 32'd0);
        bus.rd_en_i = 1'b0;
        cyc();
        rst = 1'b0;
        cyc(); cyc();
        chk("end.rd_valid", 32'(bus.rd_valid_o), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
